// File: rtl/qspi_flash_responder_pkg.sv
// qspi_resp_pkg: states and protocol constants shared by the QSPI flash responder.
package qspi_resp_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam int DUMMY_CYCLES = 8;
    localparam int FLASH_ADDR_BITS = 24;
endpackage

// File: rtl/qspi_flash_responder_if.sv
// qspi_flash_responder_if: QSPI pad signals plus the byte-wide memory read port of the responder.
interface qspi_flash_responder_if #(parameter int ADDR_W = 24);
    logic qsclk_i;
    logic qcs_i;
    logic [3:0] qsd_i;
    logic [3:0] qsd_o;
    logic [3:0] qsd_oe_o;
    logic mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic busy_o;
    modport slave (
        input qsclk_i, qcs_i, qsd_i, mem_rdata_i,
        output qsd_o, qsd_oe_o, mem_req_o, mem_addr_o, busy_o
    );
    modport master (
        output qsclk_i, qcs_i, qsd_i, mem_rdata_i,
        input qsd_o, qsd_oe_o, mem_req_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/qspi_flash_responder_sync.sv
// qspi_resp_sync: 2-flop synchronizer with a third register for edge detection.
module qspi_resp_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s <= {3{RST_VAL}};
        else s <= {s[1:0], d};
    end
    assign level = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: serves QSPI flash READ commands from a byte-wide synchronous memory.
// Define QSPI_RESP_QUAD_EN to add the 0x6B quad-output read with its dummy phase.
module qspi_flash_responder
    import qspi_resp_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input logic clk_i,
    input logic rst_ni,
    qspi_flash_responder_if.slave bus
);
    logic sck_rise, sck_fall, sck_lvl_unused, cs_lvl, cs_rise, cs_fall;
    logic sck_r, sck_f, sd_meta, sd;
    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [23:0] sr, sr_n, sin;
    logic [ADDR_W-1:0] addr, addr_n, maddr_n;
    logic [7:0] dsr, dsr_n, pf, pf_n;
    logic to_pf, to_pf_n, rd_vld, req_n, last;
    logic [3:0] qo_n, oe_n;
`ifdef QSPI_RESP_QUAD_EN
    logic quad, quad_n;
`endif

    qspi_resp_sync u_sck (.clk(clk_i), .rst_n(rst_ni), .d(bus.qsclk_i),
                          .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
    qspi_resp_sync #(.RST_VAL(1'b1)) u_cs (.clk(clk_i), .rst_n(rst_ni), .d(bus.qcs_i),
                                           .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

    // cs_lvl is already high in the cycle a qcs rise is seen, so that qsclk edge is dropped
    assign sck_r = sck_rise & ~cs_lvl;
    assign sck_f = sck_fall & ~cs_lvl;
    assign sin = {sr[22:0], sd};
    assign bus.busy_o = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sd_meta <= 1'b0;
            sd <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            addr <= '0;
            dsr <= '0;
            pf <= '0;
            to_pf <= 1'b0;
            rd_vld <= 1'b0;
            bus.qsd_o <= '0;
            bus.qsd_oe_o <= '0;
            bus.mem_req_o <= 1'b0;
            bus.mem_addr_o <= '0;
        end else begin
            sd_meta <= bus.qsd_i[0];
            sd <= sd_meta;
            state <= state_n;
            cnt <= cnt_n;
            sr <= sr_n;
            addr <= addr_n;
            dsr <= dsr_n;
            pf <= pf_n;
            to_pf <= to_pf_n;
            rd_vld <= bus.mem_req_o & ~cs_rise;
            bus.qsd_o <= qo_n;
            bus.qsd_oe_o <= oe_n;
            bus.mem_req_o <= req_n;
            bus.mem_addr_o <= maddr_n;
        end
    end

`ifdef QSPI_RESP_QUAD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) quad <= 1'b0;
        else quad <= quad_n;
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sr_n = sr;
        addr_n = addr;
        dsr_n = dsr;
        pf_n = pf;
        to_pf_n = to_pf;
        req_n = 1'b0;
        maddr_n = bus.mem_addr_o;
        qo_n = bus.qsd_o;
        oe_n = bus.qsd_oe_o;
        last = 1'b0;
`ifdef QSPI_RESP_QUAD_EN
        quad_n = quad;
`endif
        // read data arrives one cycle after the strobe; to_pf says where it belongs
        if (rd_vld) begin
            if (to_pf) pf_n = bus.mem_rdata_i;
            else dsr_n = bus.mem_rdata_i;
        end
        if (cs_rise) begin
            state_n = IDLE;
            cnt_n = '0;
            qo_n = '0;
            oe_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (cs_fall) state_n = CMD;
                end
                CMD: if (sck_r) begin
                    sr_n = sin;
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd7) begin
                        cnt_n = '0;
`ifdef QSPI_RESP_QUAD_EN
                        quad_n = sin[7:0] == CMD_QREAD;
                        state_n = (sin[7:0] == CMD_READ || quad_n) ? ADDR : IGNORE;
`else
                        state_n = sin[7:0] == CMD_READ ? ADDR : IGNORE;
`endif
                    end
                end
                ADDR: if (sck_r) begin
                    sr_n = sin;
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'(FLASH_ADDR_BITS - 1)) begin
                        cnt_n = '0;
                        addr_n = sin[ADDR_W-1:0];
                        maddr_n = sin[ADDR_W-1:0];
                        req_n = 1'b1;
                        to_pf_n = 1'b0;
`ifdef QSPI_RESP_QUAD_EN
                        state_n = quad ? DUMMY : DATA;
`else
                        state_n = DATA;
`endif
                    end
                end
`ifdef QSPI_RESP_QUAD_EN
                DUMMY: if (sck_r) begin
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'(DUMMY_CYCLES - 1)) begin
                        cnt_n = '0;
                        state_n = DATA;
                    end
                end
`endif
                DATA: if (sck_f) begin
                    // launching a byte's first beat fetches the following byte into pf
                    if (cnt == 5'd0) begin
                        addr_n = addr + 1'b1;
                        maddr_n = addr_n;
                        req_n = 1'b1;
                        to_pf_n = 1'b1;
                    end
`ifdef QSPI_RESP_QUAD_EN
                    if (quad) begin
                        qo_n = dsr[7:4];
                        oe_n = 4'b1111;
                        dsr_n = {dsr[3:0], 4'h0};
                        last = cnt == 5'd1;
                    end else
`endif
                    begin
                        qo_n = {2'b00, dsr[7], 1'b0};
                        oe_n = 4'b0010;
                        dsr_n = {dsr[6:0], 1'b0};
                        last = cnt == 5'd7;
                    end
                    if (last) begin
                        cnt_n = '0;
                        dsr_n = pf;
                    end else cnt_n = cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: randomized QSPI reads on a 24-bit and an 8-bit address instance,
// checked against a byte-array flash model (byte at address A is mem[A mod 256]).
`timescale 1ns/1ps
module tb_qspi_flash_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic qsclk = 1'b0;
    logic qcs = 1'b1;
    logic [3:0] qsd = 4'h0;
    logic [7:0] mem [256];
    logic [23:0] q24 [$];
    logic [7:0] q8 [$];
    logic [3:0] s24, e24, s8, e8;
    logic oe_seen;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qspi_flash_responder_if #(.ADDR_W(24)) b24 ();
    qspi_flash_responder_if #(.ADDR_W(8)) b8 ();
    assign b24.qsclk_i = qsclk;
    assign b24.qcs_i = qcs;
    assign b24.qsd_i = qsd;
    assign b8.qsclk_i = qsclk;
    assign b8.qcs_i = qcs;
    assign b8.qsd_i = qsd;

    qspi_flash_responder #(.ADDR_W(24)) dut24 (.clk_i(clk), .rst_ni(rst_n), .bus(b24));
    qspi_flash_responder #(.ADDR_W(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8));

    // synchronous memory: data valid the cycle after the strobe; every strobe cycle is logged
    always @(posedge clk) begin
        if (b24.mem_req_o) begin
            b24.mem_rdata_i <= mem[b24.mem_addr_o[7:0]];
            q24.push_back(b24.mem_addr_o);
        end
        if (b8.mem_req_o) begin
            b8.mem_rdata_i <= mem[b8.mem_addr_o];
            q8.push_back(b8.mem_addr_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one qsclk period (12 clk): set data low, sample DUT just before the rising edge
    task automatic pulse(input logic b);
        qsd[0] = b;
        tick(6);
        s24 = b24.qsd_o;
        e24 = b24.qsd_oe_o;
        s8 = b8.qsd_o;
        e8 = b8.qsd_oe_o;
        oe_seen = oe_seen | (|(e24 | e8));
        qsclk = 1'b1;
        tick(6);
        qsclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [23:0] a, input int nclk);
        bit rd, qd;
        int bpb, nreq;
        logic [7:0] byt;
        logic [3:0] want;
        rd = cmd == 8'h03;
`ifdef QSPI_RESP_QUAD_EN
        qd = cmd == 8'h6B;
`else
        qd = 1'b0;
`endif
        bpb = qd ? 2 : 8;
        q24.delete();
        q8.delete();
        oe_seen = 1'b0;
        qcs = 1'b0;
        tick(6);
        check("busy_start", {b24.busy_o, b8.busy_o}, 2'b11);
        for (int i = 7; i >= 0; i--) pulse(cmd[i]);
        for (int i = 23; i >= 0; i--) pulse(a[i]);
        if (qd) for (int i = 0; i < 8; i++) pulse(1'b0);
        check("quiet_hdr", oe_seen, 0);
        for (int k = 0; k < nclk; k++) begin
            pulse(1'($urandom_range(0, 1)));
            if (rd || qd) begin
                byt = mem[8'(a + 24'(k / bpb))];
                want = qd ? ((k % 2 == 0) ? byt[7:4] : byt[3:0]) : {2'b00, byt[7 - k % 8], 1'b0};
                check("qsd24", s24, want);
                check("qsd8", s8, want);
                check("oe24", e24, qd ? 4'hF : 4'h2);
                check("oe8", e8, qd ? 4'hF : 4'h2);
            end
        end
        if (!(rd || qd)) check("quiet_ign", oe_seen, 0);
        tick(6);
        qcs = 1'b1;
        tick(4);
        check("oe_end", {b24.qsd_oe_o, b8.qsd_oe_o}, 0);
        check("busy_end", {b24.busy_o, b8.busy_o}, 0);
        tick(6);
        // every launched byte prefetches its successor; the trailing fall launches one more beat
        nreq = (rd || qd) ? 1 + (nclk + bpb) / bpb : 0;
        check("nreq24", q24.size(), nreq);
        check("nreq8", q8.size(), nreq);
        for (int i = 0; i < nreq && i < q24.size(); i++) check("addr24", q24[i], 24'(a + 24'(i)));
        for (int i = 0; i < nreq && i < q8.size(); i++) check("addr8", q8[i], 8'(a + 24'(i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_qsd"}, {b24.qsd_o, b8.qsd_o}, 0);
        check({tag, "_oe"}, {b24.qsd_oe_o, b8.qsd_oe_o}, 0);
        check({tag, "_req"}, {b24.mem_req_o, b8.mem_req_o}, 0);
        check({tag, "_addr24"}, b24.mem_addr_o, 0);
        check({tag, "_addr8"}, b8.mem_addr_o, 0);
        check({tag, "_busy"}, {b24.busy_o, b8.busy_o}, 0);
    endtask

    initial begin
        logic [7:0] c;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        mem[8'h20] = 8'h12;
        mem[8'h21] = 8'h34;
        tick(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick(3);
        xfer(8'h03, 24'h000010, 16);
        xfer(8'h6B, 24'h000020, 4);
        xfer(8'h03, 24'h0000FF, 16);
        xfer(8'h9F, 24'($urandom), 16);
        xfer(8'h03, 24'($urandom), 16);
        xfer(8'h03, 24'($urandom), 12);
        xfer(8'h03, 24'h000010, 8);
        qcs = 1'b0;
        tick(6);
        for (int i = 7; i >= 0; i--) pulse(1'(8'h03 >> i));
        for (int i = 0; i < 10; i++) pulse(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        qcs = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("busy_after_rst", {b24.busy_o, b8.busy_o}, 0);
        xfer(8'h03, 24'($urandom), 10);
        xfer(8'h03, 24'hFFFFFE, 24);
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0, 1: c = 8'h03;
                2: c = 8'h6B;
                default: c = 8'($urandom);
            endcase
            xfer(c, 24'($urandom), int'($urandom_range(1, 24)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
